// File: rtl/vote_ballot_latch.sv
// -----------------------------------------------------------------------------
// vote_ballot_latch
//
// Conditioning stage in front of the voting OR stage. Each raw voter button is
// synchronised (2 flops), debounced, and turned into a one-cycle vote event on
// the debounced 0->1 edge. A three-state ballot round (IDLE -> OPEN -> CLOSED)
// locks each voter's first event of the round into ballot_o. It also keeps a
// registered yes-count and a strict-majority flag for the closed round.
//
// Ports
//   clk             single clock for the whole block
//   rst             synchronous, active-high reset
//   voter_i         raw asynchronous voter buttons, 1 = pressed
//   open_i          start a round (taken in IDLE only)
//   close_i         end the round (taken in OPEN only)
//   ack_i           result consumed, return to IDLE (taken in CLOSED only)
//   ballot_o        locked votes for this round, drives the OR stage
//   yes_count_o     popcount of ballot_o, registered alongside it
//   majority_o      yes_count_o*2 > N_VOTERS, meaningful while result_valid_o=1
//   result_valid_o  high while the round is CLOSED
//   state_o         00=IDLE 01=OPEN 10=CLOSED
//
// Latency: a raw level that is stable from clock edge t sets its ballot_o
// bit at edge t+DEBOUNCE_CYCLES+3 (2 sync flops, DEBOUNCE_CYCLES debounce
// samples, 1 edge-detect register, 1 ballot register).
// -----------------------------------------------------------------------------
module vote_ballot_latch #(
    parameter int N_VOTERS        = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_VOTERS-1:0] voter_i,
    input  logic                open_i,
    input  logic                close_i,
    input  logic                ack_i,
    output logic [N_VOTERS-1:0] ballot_o,
    output logic [CNT_W-1:0]    yes_count_o,
    output logic                majority_o,
    output logic                result_valid_o,
    output logic [1:0]          state_o
);

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1; the sample
    // that would make it DEBOUNCE_CYCLES flips the level instead.
    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OPEN   = 2'b01,
        ST_CLOSED = 2'b10
    } state_t;

    // Zero-extended population count of a ballot vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Strict majority, compared one bit wider than the count so doubling
    // cannot wrap.
    function automatic logic majority(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] twice;
        twice = {cnt, 1'b0};
        return twice > (CNT_W + 1)'(N_VOTERS);
    endfunction

    logic [N_VOTERS-1:0] sync_p0;
    logic [N_VOTERS-1:0] sync_p1;
    logic [N_VOTERS-1:0] deb_p2;
    logic [DB_W-1:0]     db_cnt_p2 [N_VOTERS];
    logic [N_VOTERS-1:0] deb_prev_p3;
    logic [N_VOTERS-1:0] vote_evt_p3;

    state_t              state_q;
    logic [N_VOTERS-1:0] ballot_nxt;
    logic [CNT_W-1:0]    count_nxt;

    // ---- stage p0/p1: two-flop synchroniser --------------------------------
    // ---- stage p2: per-voter debouncer -------------------------------------
    // ---- stage p3: registered rising-edge vote event -----------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0     <= '0;
            sync_p1     <= '0;
            deb_p2      <= '0;
            deb_prev_p3 <= '0;
            vote_evt_p3 <= '0;
            for (int k = 0; k < N_VOTERS; k++) begin
                db_cnt_p2[k] <= '0;
            end
        end else begin
            sync_p0 <= voter_i;
            sync_p1 <= sync_p0;
            for (int k = 0; k < N_VOTERS; k++) begin
                if (sync_p1[k] != deb_p2[k]) begin
                    if (db_cnt_p2[k] == DB_LAST) begin
                        deb_p2[k]    <= sync_p1[k];
                        db_cnt_p2[k] <= '0;
                    end else begin
                        db_cnt_p2[k] <= db_cnt_p2[k] + DB_W'(1);
                    end
                end else begin
                    // Any agreeing sample restarts the run of disagreements.
                    db_cnt_p2[k] <= '0;
                end
            end
            deb_prev_p3 <= deb_p2;
            vote_evt_p3 <= deb_p2 & ~deb_prev_p3;
        end
    end

    // Ballot/count as they would be after absorbing this cycle's events; a
    // vote arriving together with close_i is therefore still counted.
    always_comb begin
        ballot_nxt = ballot_o | vote_evt_p3;
        count_nxt  = popcount(ballot_nxt);
    end

    // ---- stage p4: ballot round FSM and registered results -----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ballot_o       <= '0;
            yes_count_o    <= '0;
            majority_o     <= 1'b0;
            result_valid_o <= 1'b0;
        end else begin
            case (state_q)
                ST_OPEN: begin
                    ballot_o    <= ballot_nxt;
                    yes_count_o <= count_nxt;
                    // Auto-close looks at the registered ballot, so a full
                    // ballot closes on the cycle after it appears.
                    if (close_i || (&ballot_o)) begin
                        state_q        <= ST_CLOSED;
                        result_valid_o <= 1'b1;
                        majority_o     <= majority(count_nxt);
                    end
                end
                ST_CLOSED: begin
                    if (ack_i) begin
                        state_q        <= ST_IDLE;
                        ballot_o       <= '0;
                        yes_count_o    <= '0;
                        majority_o     <= 1'b0;
                        result_valid_o <= 1'b0;
                    end
                end
                default: begin
                    // IDLE, and the unused encoding behaves as IDLE.
                    state_q        <= ST_IDLE;
                    ballot_o       <= '0;
                    yes_count_o    <= '0;
                    majority_o     <= 1'b0;
                    result_valid_o <= 1'b0;
                    if (open_i) begin
                        state_q <= ST_OPEN;
                    end
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule
